axis_xfer_sequencer: RTL and testbench



---
 rtl/axis_xfer_sequencer.sv | 143 ++++++++++++++
 tb/tb_axis_xfer_sequencer.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// axis_xfer_sequencer : gates one software-sized AXI4-Stream transfer, forces
//                       tlast and the partial tkeep on its final beat.
// Revision            : 1.0
// ============================================================================
module axis_xfer_sequencer #(
    parameter int C_TDATA_WIDTH = 256,
    parameter int C_SIZE_WIDTH  = 32
) (
    input  logic                       aclk,
    input  logic                       areset,

    input  logic                       ctrl_start,
    input  logic [C_SIZE_WIDTH-1:0]    ctrl_xfer_size_in_bytes,
    output logic                       ctrl_busy,
    output logic                       ctrl_done,
    output logic                       ctrl_err,
    output logic [C_SIZE_WIDTH-1:0]    beat_count,

    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [C_TDATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_TDATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic                       s_axis_tlast,

    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready,
    output logic [C_TDATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_TDATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                       m_axis_tlast
);

    localparam int                      c_BYTES      = C_TDATA_WIDTH / 8;
    localparam int                      c_LOG2_BYTES = $clog2(c_BYTES);
    localparam logic [C_SIZE_WIDTH-1:0] c_REM_MASK   = C_SIZE_WIDTH'(c_BYTES - 1);
    localparam logic [C_SIZE_WIDTH-1:0] c_ONE        = C_SIZE_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                    r_state;
    logic [C_SIZE_WIDTH-1:0]   r_last_idx;
    logic [c_BYTES-1:0]        r_keep_mask;
    logic [C_SIZE_WIDTH-1:0]   r_beat_count;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_err;

    logic                      w_run;
    logic                      w_hs;
    logic                      w_final;
    logic                      w_size_zero;
    logic [C_SIZE_WIDTH-1:0]   w_size_rem;
    logic [C_SIZE_WIDTH-1:0]   w_last_idx;
    logic [c_BYTES-1:0]        w_keep_mask;

    // Index of the final beat, N-1 = floor((S-1)/B); only used when S > 0,
    // so it can never overflow even at the largest size.
    assign w_size_zero = (ctrl_xfer_size_in_bytes == '0);
    assign w_size_rem  = ctrl_xfer_size_in_bytes & c_REM_MASK;
    assign w_last_idx  = (ctrl_xfer_size_in_bytes - c_ONE) >> c_LOG2_BYTES;

    generate
        for (genvar i = 0; i < c_BYTES; i++) begin : g_keep_mask
            assign w_keep_mask[i] = (w_size_rem == '0) || (C_SIZE_WIDTH'(i) < w_size_rem);
        end
    endgenerate

    assign w_run   = (r_state == ST_RUN);
    assign w_hs    = w_run && s_axis_tvalid && m_axis_tready;
    assign w_final = w_run && (r_beat_count == r_last_idx);

    assign m_axis_tvalid = w_run && s_axis_tvalid;
    assign s_axis_tready = w_run && m_axis_tready;
    assign m_axis_tdata  = s_axis_tdata;
    assign m_axis_tkeep  = w_final ? (s_axis_tkeep & r_keep_mask) : s_axis_tkeep;
    assign m_axis_tlast  = w_run && (w_final || s_axis_tlast);

    assign ctrl_busy  = r_busy;
    assign ctrl_done  = r_done;
    assign ctrl_err   = r_err;
    assign beat_count = r_beat_count;

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state      <= ST_IDLE;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_beat_count <= '0;
            r_last_idx   <= '0;
            r_keep_mask  <= '1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ctrl_start) begin
                        r_last_idx   <= w_last_idx;
                        r_keep_mask  <= w_keep_mask;
                        r_beat_count <= '0;
                        r_err        <= 1'b0;
                        if (w_size_zero) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (w_hs) begin
                        r_beat_count <= r_beat_count + c_ONE;
                        // An upstream tlast ahead of the final beat ends the
                        // transfer but is flagged as an error.
                        if (w_final || s_axis_tlast) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            if (!w_final) begin
                                r_err <= 1'b1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axis_xfer_sequencer.sv
`default_nettype none
// ============================================================================
// tb_axis_xfer_sequencer : directed scoreboard bench for axis_xfer_sequencer.
// Revision               : 1.0
// ============================================================================
module tb_axis_xfer_sequencer;

    localparam int W  = 256;
    localparam int SW = 32;
    localparam int KW = W / 8;

    logic          clk = 1'b0;
    logic          areset;
    logic          ctrl_start;
    logic [SW-1:0] ctrl_xfer_size_in_bytes;
    logic          ctrl_busy;
    logic          ctrl_done;
    logic          ctrl_err;
    logic [SW-1:0] beat_count;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [W-1:0]  s_axis_tdata;
    logic [KW-1:0] s_axis_tkeep;
    logic          s_axis_tlast;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [W-1:0]  m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [KW-1:0] keep;
        logic          last;
    } beat_t;

    beat_t sb[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;
    logic  hs;

    always #5 clk = ~clk;

    axis_xfer_sequencer #(
        .C_TDATA_WIDTH (W),
        .C_SIZE_WIDTH  (SW)
    ) dut (
        .aclk                    (clk),
        .areset                  (areset),
        .ctrl_start              (ctrl_start),
        .ctrl_xfer_size_in_bytes (ctrl_xfer_size_in_bytes),
        .ctrl_busy               (ctrl_busy),
        .ctrl_done               (ctrl_done),
        .ctrl_err                (ctrl_err),
        .beat_count              (beat_count),
        .s_axis_tvalid           (s_axis_tvalid),
        .s_axis_tready           (s_axis_tready),
        .s_axis_tdata            (s_axis_tdata),
        .s_axis_tkeep            (s_axis_tkeep),
        .s_axis_tlast            (s_axis_tlast),
        .m_axis_tvalid           (m_axis_tvalid),
        .m_axis_tready           (m_axis_tready),
        .m_axis_tdata            (m_axis_tdata),
        .m_axis_tkeep            (m_axis_tkeep),
        .m_axis_tlast            (m_axis_tlast)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: settle inputs, score any handshake, cross the edge, then
    // sample registered outputs on the falling edge.
    task automatic cycle();
        beat_t e;
        #1;
        hs = m_axis_tvalid && m_axis_tready;
        if (hs) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", {{(W-1){1'b0}}, hs}, '0);
            end else begin
                e = sb.pop_front();
                chk("beat_data", m_axis_tdata, e.data);
                chk("beat_keep", {{(W-KW){1'b0}}, m_axis_tkeep}, {{(W-KW){1'b0}}, e.keep});
                chk("beat_last", {{(W-1){1'b0}}, m_axis_tlast}, {{(W-1){1'b0}}, e.last});
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (ctrl_done) done_cnt++;
    endtask

    function automatic logic [W-1:0] rdata();
        logic [W-1:0] d;
        for (int i = 0; i < W / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic start(input logic [SW-1:0] size);
        ctrl_start              = 1'b1;
        ctrl_xfer_size_in_bytes = size;
        cycle();
        ctrl_start              = 1'b0;
        ctrl_xfer_size_in_bytes = $urandom;
    endtask

    task automatic send_beat(input logic [W-1:0] d, input logic [KW-1:0] k, input logic sl,
                             input logic [KW-1:0] ek, input logic el, input bit rnd);
        beat_t e;
        e.data = d;
        e.keep = ek;
        e.last = el;
        sb.push_back(e);
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = sl;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 64; n++) begin
            m_axis_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            if (hs) break;
        end
        chk("beat_accepted", {{(W-1){1'b0}}, hs}, 1);
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_tready = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        areset                  = 1'b1;
        ctrl_start              = 1'b0;
        ctrl_xfer_size_in_bytes = '0;
        s_axis_tvalid           = 1'b1;
        s_axis_tdata            = '0;
        s_axis_tkeep            = '1;
        s_axis_tlast            = 1'b1;
        m_axis_tready           = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_busy",   ctrl_busy,     0);
        chk("rst_done",   ctrl_done,     0);
        chk("rst_err",    ctrl_err,      0);
        chk("rst_count",  beat_count,    0);
        chk("rst_mvalid", m_axis_tvalid, 0);
        chk("rst_sready", s_axis_tready, 0);
        chk("rst_mlast",  m_axis_tlast,  0);
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        cycle();

        // S=100: 4 beats, final keep 0xF
        done_cnt = 0;
        start(100);
        chk("s100_busy", ctrl_busy, 1);
        for (int i = 0; i < 4; i++)
            send_beat(rdata(), '1, 1'b0, (i == 3) ? KW'(32'h0000000F) : '1, i == 3, 0);
        chk("s100_busy_end", ctrl_busy,  0);
        chk("s100_done",     ctrl_done,  1);
        chk("s100_count",    beat_count, 4);
        chk("s100_err",      ctrl_err,   0);
        cycle();
        chk("s100_done_low", ctrl_done, 0);
        chk("s100_done_cnt", done_cnt,  1);

        // S=64 under random backpressure
        done_cnt = 0;
        start(64);
        for (int i = 0; i < 2; i++)
            send_beat(rdata(), '1, 1'b0, '1, i == 1, 1);
        chk("s64_count", beat_count, 2);
        chk("s64_done",  ctrl_done,  1);
        cycle();
        chk("s64_done_cnt", done_cnt,  1);
        chk("s64_sb_empty", sb.size(), 0);

        // S=128 with upstream tlast on beat 2
        start(128);
        send_beat(rdata(), '1, 1'b0, '1, 1'b0, 0);
        send_beat(rdata(), KW'(32'h0F0F0F0F), 1'b1, KW'(32'h0F0F0F0F), 1'b1, 0);
        chk("early_err",   ctrl_err,   1);
        chk("early_count", beat_count, 2);
        chk("early_done",  ctrl_done,  1);
        cycle();
        start(32);
        chk("s32_err_clr", ctrl_err,  0);
        chk("s32_busy",    ctrl_busy, 1);
        send_beat(rdata(), '1, 1'b0, '1, 1'b1, 0);
        chk("s32_done", ctrl_done, 1);
        chk("s32_err",  ctrl_err,  0);
        cycle();

        // S=0: immediate done, nothing passes
        done_cnt      = 0;
        s_axis_tvalid = 1'b1;
        start(0);
        chk("s0_done",   ctrl_done,     1);
        chk("s0_busy",   ctrl_busy,     0);
        chk("s0_mvalid", m_axis_tvalid, 0);
        chk("s0_sready", s_axis_tready, 0);
        cycle();
        chk("s0_done_low", ctrl_done,     0);
        chk("s0_mvalid2",  m_axis_tvalid, 0);
        s_axis_tvalid = 1'b0;
        chk("s0_done_cnt", done_cnt, 1);

        // start held through RUN and DONE is ignored
        done_cnt = 0;
        start(64);
        ctrl_start              = 1'b1;
        ctrl_xfer_size_in_bytes = '0;
        send_beat(rdata(), '1, 1'b0, '1, 1'b0, 0);
        send_beat(rdata(), '1, 1'b0, '1, 1'b1, 0);
        cycle();
        ctrl_start = 1'b0;
        chk("ign_done_low", ctrl_done, 0);
        cycle();
        cycle();
        chk("ign_busy",     ctrl_busy,  0);
        chk("ign_count",    beat_count, 2);
        chk("ign_done_cnt", done_cnt,   1);

        // reset in the middle of a 10-beat transfer
        done_cnt = 0;
        start(320);
        send_beat(rdata(), '1, 1'b0, '1, 1'b0, 0);
        send_beat(rdata(), '1, 1'b0, '1, 1'b0, 0);
        chk("mid_count", beat_count, 2);
        areset = 1'b1;
        cycle();
        chk("mrst_busy",  ctrl_busy,  0);
        chk("mrst_count", beat_count, 0);
        chk("mrst_done",  ctrl_done,  0);
        s_axis_tvalid = 1'b1;
        m_axis_tready = 1'b1;
        #1;
        chk("mrst_sready", s_axis_tready, 0);
        chk("mrst_mvalid", m_axis_tvalid, 0);
        chk("mrst_mlast",  m_axis_tlast,  0);
        areset        = 1'b0;
        s_axis_tvalid = 1'b0;
        cycle();
        chk("mrst_no_done", done_cnt,  0);
        chk("mrst_busy2",   ctrl_busy, 0);
        start(32);
        send_beat(rdata(), '1, 1'b0, '1, 1'b1, 0);
        chk("fresh_done",  ctrl_done,  1);
        chk("fresh_count", beat_count, 1);
        cycle();
        chk("fresh_done_cnt", done_cnt,  1);
        chk("final_sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
